// File: rtl/imem_pkg.sv
// imem_pkg: shared word width, default memory depth, response buffer
// occupancy states and the buffered response record for the fetch responder.
package imem_pkg;

    localparam int unsigned IMEM_WORD_W          = 32;
    localparam int unsigned IMEM_DEPTH_WORDS_DEF = 256;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } imem_occ_e;

    typedef struct packed {
        logic [IMEM_WORD_W-1:0] addr;
        logic [IMEM_WORD_W-1:0] instr;
        logic                   err;
    } imem_resp_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: two-entry in-order buffer of fetch responses.
// head_q is always the oldest entry and drives the output directly, so the
// response fields only change when the head is popped.
module imem_resp_fifo
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  imem_resp_t wdata_i,
    output logic       valid_o,
    output logic [1:0] count_o,
    output imem_resp_t rdata_o
);

    imem_occ_e  state_q;
    imem_resp_t head_q;
    imem_resp_t tail_q;

    // Occupancy FSM with the two storage slots; flush empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush_i) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_q  <= wdata_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    case ({push_i, pop_i})
                        2'b11: head_q <= wdata_i;
                        2'b10: begin
                            tail_q  <= wdata_i;
                            state_q <= FULL;
                        end
                        2'b01: state_q <= EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (push_i) begin
                            tail_q <= wdata_i;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign valid_o = (state_q != EMPTY);
    assign count_o = state_q;
    assign rdata_o = head_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction memory with a valid/ready fetch port,
// one-cycle read latency and a two-entry response buffer.
// Optional feature macro: IMEM_MISALIGN_CHECK_EN flags requests whose byte
// address is not word aligned (resp_err=1, resp_instr=0, no memory read).
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS_DEF,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [IMEM_WORD_W-1:0]         req_addr,
    input  logic                           flush,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [IMEM_WORD_W-1:0]         resp_instr,
    output logic [IMEM_WORD_W-1:0]         resp_addr,
    output logic                           resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [IMEM_WORD_W-1:0]         ld_data
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  BUF_DEPTH_C = 2'(BUF_DEPTH);

    logic [IMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [AW-1:0]          rd_idx;
    logic                   accept;
    logic                   pop;
    logic [1:0]             occ_count;
    imem_resp_t             push_d;
    imem_resp_t             head;

    assign rd_idx = req_addr[AW+1:2];
    assign pop    = resp_valid & resp_ready;
    assign accept = req_valid & req_ready;

    // A full buffer still accepts when its head leaves in the same cycle.
    assign req_ready = ~rst & ~flush & ((occ_count < BUF_DEPTH_C) | pop);

    // Memory load port; not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Response record captured into the buffer at the accepting edge; the
    // read sees pre-load contents when a load hits the same word.
    always_comb begin
        push_d      = '0;
        push_d.addr = req_addr;
`ifdef IMEM_MISALIGN_CHECK_EN
        push_d.err   = |req_addr[1:0];
        push_d.instr = push_d.err ? '0 : mem_q[rd_idx];
`else
        push_d.err   = 1'b0;
        push_d.instr = mem_q[rd_idx];
`endif
    end

    imem_resp_fifo u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (push_d),
        .valid_o (resp_valid),
        .count_o (occ_count),
        .rdata_o (head)
    );

    assign resp_instr = head.instr;
    assign resp_addr  = head.addr;
    assign resp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed bench with an in-order scoreboard and a
// bench-side copy of the memory contents.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [256];
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS (256),
        .BUF_DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        e.addr = a;
`ifdef IMEM_MISALIGN_CHECK_EN
        e.err   = |a[1:0];
        e.instr = e.err ? 32'h0 : mdl_mem[a[9:2]];
`else
        e.err   = 1'b0;
        e.instr = mdl_mem[a[9:2]];
`endif
        return e;
    endfunction

    // One clock cycle: inputs are already applied just after the previous edge.
    task automatic cyc();
        logic exp_rdy;
        exp_t push_e;
        #2;
        if (rst) begin
            sb.delete();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_instr", resp_instr, 0);
            chk("rst_resp_addr", resp_addr, 0);
            chk("rst_resp_err", resp_err, 0);
        end else begin
            exp_rdy = !flush && (sb.size() < 2 || resp_ready);
            chk("req_ready", req_ready, exp_rdy);
            chk("resp_valid", resp_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                chk("resp_addr", resp_addr, sb[0].addr);
                chk("resp_instr", resp_instr, sb[0].instr);
                chk("resp_err", resp_err, sb[0].err);
            end
            push_e = model_fetch(req_addr);
            if (sb.size() != 0 && resp_ready) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (req_valid && exp_rdy) sb.push_back(push_e);
            if (ld_en) mdl_mem[ld_addr] = ld_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rv, input logic [31:0] a, input logic rr, input logic fl);
        req_valid  = rv;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        cyc();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_instr"}, resp_instr, 0);
        chk({tag, "_addr"}, resp_addr, 0);
        chk({tag, "_err"}, resp_err, 0);
        chk({tag, "_valid"}, resp_valid, 0);
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h00000013;
        prog[1] = 32'h00100093;
        prog[2] = 32'h00200113;
        prog[3] = 32'h00300193;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        resp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk_zero_outputs("post_rst");
        step(0, 0, 0, 0);

        // Load program words 0..3 and filler words up to word 8.
        for (int i = 0; i < 9; i++) begin
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ld_data = (i < 4) ? prog[i] : 32'h1000_0000 + 32'(i);
            step(0, 0, 1, 0);
        end
        ld_en = 1'b0;

        // Back-to-back fetches.
        step(1, 32'h0, 1, 0);
        step(1, 32'h4, 1, 0);
        step(1, 32'h8, 1, 0);
        step(1, 32'hC, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Backpressure: third request waits until the head is popped.
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'h8, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Flush with two buffered responses, pop in the flush cycle.
        step(1, 32'h10, 0, 0);
        step(1, 32'h14, 0, 0);
        step(1, 32'h18, 1, 1);
        step(1, 32'h20, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Reset while a response is stalled.
        step(1, 32'h4, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        rst = 1'b0;
        #1;
        chk_zero_outputs("rel_rst");
        step(0, 0, 1, 0);
        step(1, 32'h0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Misaligned request.
        step(1, 32'h6, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Load and fetch of the same word in one cycle.
        ld_en   = 1'b1;
        ld_addr = 8'd2;
        ld_data = 32'hDEADBEEF;
        step(1, 32'h8, 1, 0);
        ld_en = 1'b0;
        step(1, 32'h8, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Mixed random traffic over the loaded region, including address wrap.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {22'($urandom_range(0, 3)), 8'($urandom_range(0, 8)), 2'b00};
            step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), 1'(i % 13 == 12));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
